// File: rtl/text_buffer_ctrl_pkg.sv
// Shared character codes and controller state encoding for the text buffer.
package text_buffer_ctrl_pkg;

    localparam logic [7:0] CharTilde = 8'h7E;
    localparam logic [7:0] CharBs    = 8'h08;
    localparam logic [7:0] CharLf    = 8'h0A;
    localparam logic [7:0] CharFf    = 8'h0C;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec  = 2'd1,
        StClear = 2'd2
    } state_e;

endpackage

// File: rtl/text_buffer_ctrl.sv
// Text buffer controller: owns the character memory port, executes a character
// stream against a write cursor and yields the port to the display reader.
module text_buffer_ctrl
    import text_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned LINE_LEN = 16,
    parameter int unsigned AW       = 8,
    parameter logic [7:0]  FILL     = CharTilde
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ch_valid,
    input  logic [7:0]    i_ch_data,
    output logic          o_ch_ready,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_valid,
    output logic [7:0]    o_rd_data,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_di,
    input  logic [7:0]    i_mem_do,
    output logic [AW-1:0] o_cursor,
    output logic          o_busy
);

    localparam int unsigned AW1 = AW + 1;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_cursor, w_cursor_d;
    logic [AW-1:0] r_clr_cnt, w_clr_cnt_d;
    logic [7:0]    r_char, w_char_d;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;

    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_di;
    logic [AW-1:0] w_cursor_inc;
    logic [AW-1:0] w_line_base;
    logic [AW:0]   w_lf_sum;
    logic [AW-1:0] w_lf_next;

    // Cursor arithmetic shared by printable writes and line feed.
    always_comb begin
        w_cursor_inc = (r_cursor == AW'(DEPTH - 1)) ? '0 : r_cursor + 1'b1;
        w_line_base  = r_cursor - (r_cursor % AW'(LINE_LEN));
        w_lf_sum     = {1'b0, w_line_base} + AW1'(LINE_LEN);
        // DEPTH is a multiple of LINE_LEN, so overflow past the last line is exactly 0.
        w_lf_next    = (w_lf_sum >= AW1'(DEPTH)) ? '0 : w_lf_sum[AW-1:0];
    end

    // Next-state and port drive; a display read stalls EXEC/CLEAR in place.
    always_comb begin
        w_state_d   = r_state;
        w_cursor_d  = r_cursor;
        w_clr_cnt_d = r_clr_cnt;
        w_char_d    = r_char;
        w_we        = 1'b0;
        w_addr      = r_cursor;
        w_di        = FILL;
        unique case (r_state)
            StIdle: begin
                if (i_ch_valid) begin
                    w_char_d  = i_ch_data;
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (!i_rd_req) begin
                    w_state_d = StIdle;
                    if (!r_char[7] && r_char >= 8'h20) begin
                        w_we       = 1'b1;
                        w_di       = r_char;
                        w_cursor_d = w_cursor_inc;
                    end else if (r_char == CharBs) begin
                        if (r_cursor != '0) begin
                            w_we       = 1'b1;
                            w_addr     = r_cursor - 1'b1;
                            w_cursor_d = r_cursor - 1'b1;
                        end
                    end else if (r_char == CharLf) begin
                        w_cursor_d = w_lf_next;
                    end else if (r_char == CharFf) begin
                        w_clr_cnt_d = '0;
                        w_state_d   = StClear;
                    end
                end
            end
            StClear: begin
                if (!i_rd_req) begin
                    w_we   = 1'b1;
                    w_addr = r_clr_cnt;
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        w_clr_cnt_d = '0;
                        w_cursor_d  = '0;
                        w_state_d   = StIdle;
                    end else begin
                        w_clr_cnt_d = r_clr_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (i_rd_req) begin
            w_addr = i_rd_addr;
        end
    end

    // Controller state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_cursor  <= '0;
            r_clr_cnt <= '0;
            r_char    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cursor  <= w_cursor_d;
            r_clr_cnt <= w_clr_cnt_d;
            r_char    <= w_char_d;
        end
    end

    // Display read register: one-cycle latency in every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req) begin
                r_rd_data <= i_mem_do;
            end
        end
    end

    assign o_ch_ready = (r_state == StIdle);
    assign o_busy     = (r_state != StIdle);
    assign o_mem_we   = w_we & ~i_rst;
    assign o_mem_addr = w_addr;
    assign o_mem_di   = w_di;
    assign o_cursor   = r_cursor;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl with a behavioural 128x8 memory.
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ch_valid = 1'b0;
    logic [7:0] ch_data = 8'h00;
    logic       ch_ready;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_di;
    logic [7:0] mem_do;
    logic [7:0] cursor;
    logic       busy;

    logic [7:0] mem [0:127];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    int         cyc = 0;
    int         acc_cyc = 0;
    int         ready_while_busy = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    text_buffer_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ch_valid (ch_valid),
        .i_ch_data  (ch_data),
        .o_ch_ready (ch_ready),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_di   (mem_di),
        .i_mem_do   (mem_do),
        .o_cursor   (cursor),
        .o_busy     (busy)
    );

    assign mem_do = mem[mem_addr[6:0]];

    // Memory model plus write/accept logger.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ch_valid && ch_ready) acc_cyc <= cyc;
        if (busy && ch_ready) ready_while_busy <= ready_while_busy + 1;
        if (mem_we) begin
            mem[mem_addr[6:0]] <= mem_di;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_di);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = c;
        while (!ch_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ch_ready) chk("ready_timeout", 32'(ch_ready), 32'd1);
        @(negedge clk);
        ch_valid = 1'b0;
        wait_idle(300);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] a,
                               input logic [7:0] d);
        if (wr_addr_q.size() > idx) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[idx]), 32'(a));
            chk({tag, "_data"}, 32'(wr_data_q[idx]), 32'(d));
        end else begin
            chk({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int bad;
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        // Reset state, sampled while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ch_ready), 32'd1);
        rst = 1'b0;
        clr_log();

        // 1: two printable characters.
        send_char(8'h41);
        send_char(8'h42);
        chk("ab_nwr", wr_addr_q.size(), 32'd2);
        check_write("ab_0", 0, 8'd0, 8'h41);
        check_write("ab_1", 1, 8'd1, 8'h42);
        chk("ab_cursor", 32'(cursor), 32'd2);

        // 2: backspace, including at cursor 0.
        clr_log();
        send_char(8'h08);
        chk("bs_nwr", wr_addr_q.size(), 32'd1);
        check_write("bs", 0, 8'd1, 8'h7E);
        chk("bs_cursor", 32'(cursor), 32'd1);
        send_char(8'h08);
        chk("bs2_cursor", 32'(cursor), 32'd0);
        clr_log();
        send_char(8'h08);
        chk("bs0_nwr", wr_addr_q.size(), 32'd0);
        chk("bs0_cursor", 32'(cursor), 32'd0);

        // Ignored control code and high-bit character.
        send_char(8'h01);
        send_char(8'h80);
        chk("ign_nwr", wr_addr_q.size(), 32'd0);
        chk("ign_cursor", 32'(cursor), 32'd0);

        // 3: line feed mid-line and from the last line.
        for (int i = 0; i < 5; i++) send_char(8'h61);
        chk("pre_lf_cursor", 32'(cursor), 32'd5);
        clr_log();
        send_char(8'h0A);
        chk("lf_cursor", 32'(cursor), 32'd16);
        chk("lf_nwr", wr_addr_q.size(), 32'd0);
        for (int i = 0; i < 6; i++) send_char(8'h0A);
        for (int i = 0; i < 8; i++) send_char(8'h62);
        chk("pre_lf2_cursor", 32'(cursor), 32'd120);
        clr_log();
        send_char(8'h0A);
        chk("lf_wrap_cursor", 32'(cursor), 32'd0);
        chk("lf_wrap_nwr", wr_addr_q.size(), 32'd0);

        // 4: screen clear.
        clr_log();
        ready_while_busy = 0;
        send_char(8'h0C);
        chk("ff_nwr", wr_addr_q.size(), 32'd128);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (i < wr_addr_q.size()) begin
                if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 8'h7E) bad++;
            end
        end
        chk("ff_seq_bad", bad, 32'd0);
        chk("ff_ready_busy", ready_while_busy, 32'd0);
        chk("ff_cursor", 32'(cursor), 32'd0);

        // 5: display read stalls EXEC of 'Z' for three cycles.
        clr_log();
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h5A;
        @(negedge clk);
        ch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_req  = 1'b1;
            rd_addr = 8'(10 * (i + 1));
            @(negedge clk);
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'h7E);
            chk("rd_stall_nwr", wr_addr_q.size(), 32'd0);
        end
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        wait_idle(20);
        chk("z_nwr", wr_addr_q.size(), 32'd1);
        check_write("z", 0, 8'd0, 8'h5A);
        if (wr_cyc_q.size() > 0) chk("z_delay", wr_cyc_q[0] - acc_cyc, 32'd4);
        chk("z_cursor", 32'(cursor), 32'd1);

        // 6: cursor wrap at 127, then reset in the middle of a clear.
        for (int i = 0; i < 7; i++) send_char(8'h0A);
        for (int i = 0; i < 15; i++) send_char(8'h78);
        chk("pre_q_cursor", 32'(cursor), 32'd127);
        clr_log();
        send_char(8'h51);
        check_write("q", 0, 8'd127, 8'h51);
        chk("q_cursor", 32'(cursor), 32'd0);

        clr_log();
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h0C;
        @(negedge clk);
        ch_valid = 1'b0;
        n = 0;
        while (wr_addr_q.size() < 40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_clr_nwr", wr_addr_q.size(), 32'd40);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cursor", 32'(cursor), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_nwr", wr_addr_q.size(), 32'd40);
        chk("post_rst_ready", 32'(ch_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
